// File: rtl/div_unit_pkg.sv
// Shared widths, state encodings and helpers for the MiniMIPS32 EXE-stage divider.
package div_unit_pkg;

   localparam int unsigned WIDTH       = 32;
   localparam int unsigned CNT_W       = 6;
   localparam int unsigned REG_BUS     = WIDTH;
   localparam int unsigned DOUBLE_REG_BUS = 2 * WIDTH;

   localparam logic STOP       = 1'b1;
   localparam logic NOSTOP     = 1'b0;
   localparam logic RST_ENABLE = 1'b0;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_ZERO = 2'b01,
      DIV_BUSY = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

   // HI holds the remainder, LO the quotient.
   typedef struct packed {
      logic [REG_BUS-1:0] rem;
      logic [REG_BUS-1:0] quo;
   } div_result_t;

   // Magnitude of a possibly-signed operand; 0x80000000 maps to itself (mod 2^WIDTH).
   function automatic logic [REG_BUS-1:0] op_mag(input logic [REG_BUS-1:0] x, input logic is_signed);
      return (is_signed && x[REG_BUS-1]) ? REG_BUS'(~x + REG_BUS'(1)) : x;
   endfunction

   function automatic logic [REG_BUS-1:0] neg_if(input logic [REG_BUS-1:0] x, input logic do_neg);
      return do_neg ? REG_BUS'(~x + REG_BUS'(1)) : x;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// EXE-stage <-> divider handshake: operands and control in, result and stall request out.
interface div_unit_if;
   import div_unit_pkg::*;

   logic               div_start;
   logic               div_signed;
   logic [REG_BUS-1:0] div_opdata1;
   logic [REG_BUS-1:0] div_opdata2;
   logic               div_cancel;
   logic               div_ready;
   div_result_t        div_result;
   logic               stallreq_exe;

   modport master (
      output div_start, div_signed, div_opdata1, div_opdata2, div_cancel,
      input  div_ready, div_result, stallreq_exe
   );

   modport slave (
      input  div_start, div_signed, div_opdata1, div_opdata2, div_cancel,
      output div_ready, div_result, stallreq_exe
   );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per clock,
// holds the front of the pipeline through stallreq_exe until the result is ready.
module div_unit
   import div_unit_pkg::*;
(
   input  logic      cpu_clk_50M,
   input  logic      cpu_rst_n,
   div_unit_if.slave div_bus
);

   div_state_e         state;
   logic [CNT_W-1:0]   cnt;
   logic [REG_BUS-1:0] rem;
   logic [REG_BUS-1:0] quo;
   logic [REG_BUS-1:0] dvs;
   logic               quo_neg;
   logic               rem_neg;
   logic               ready_q;
   div_result_t        result_q;

   logic [REG_BUS:0]   trial;
   logic [REG_BUS:0]   diff;
   logic               take;
   logic [REG_BUS-1:0] rem_step;
   logic [REG_BUS-1:0] quo_step;

   // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
   // A set top bit of the shifted remainder already exceeds any divisor,
   // otherwise the borrow out of the WIDTH+1-bit subtract decides.
   always_comb begin
      trial    = {rem, quo[REG_BUS-1]};
      diff     = trial - {1'b0, dvs};
      take     = trial[REG_BUS] | ~diff[REG_BUS];
      rem_step = trial[REG_BUS-1:0];
      quo_step = {quo[REG_BUS-2:0], 1'b0};
      if (take) begin
         rem_step    = diff[REG_BUS-1:0];
         quo_step[0] = 1'b1;
      end
   end

   // Control FSM with registered ready pulse and result.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (cpu_rst_n == RST_ENABLE) begin
         state    <= DIV_IDLE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         quo_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         ready_q <= 1'b0;
         if (div_bus.div_cancel) begin
            state <= DIV_IDLE;
         end else begin
            unique case (state)
               DIV_IDLE: begin
                  if (div_bus.div_start) begin
                     if (div_bus.div_opdata2 == '0) begin
                        state        <= DIV_ZERO;
                        ready_q      <= 1'b1;
                        result_q.rem <= div_bus.div_opdata1;
                        result_q.quo <= '1;
                     end else begin
                        state   <= DIV_BUSY;
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= op_mag(div_bus.div_opdata1, div_bus.div_signed);
                        dvs     <= op_mag(div_bus.div_opdata2, div_bus.div_signed);
                        quo_neg <= div_bus.div_signed &
                                   (div_bus.div_opdata1[REG_BUS-1] ^ div_bus.div_opdata2[REG_BUS-1]);
                        rem_neg <= div_bus.div_signed & div_bus.div_opdata1[REG_BUS-1];
                     end
                  end
               end
               DIV_BUSY: begin
                  if (!div_bus.div_start) begin
                     // Start vanishing mid-operation is treated like a flush.
                     state <= DIV_IDLE;
                  end else begin
                     rem <= rem_step;
                     quo <= quo_step;
                     cnt <= cnt + CNT_W'(1);
                     if (cnt == CNT_W'(WIDTH - 1)) begin
                        state        <= DIV_DONE;
                        ready_q      <= 1'b1;
                        result_q.rem <= neg_if(rem_step, rem_neg);
                        result_q.quo <= neg_if(quo_step, quo_neg);
                     end
                  end
               end
               DIV_ZERO, DIV_DONE: state <= DIV_IDLE;
               default:            state <= DIV_IDLE;
            endcase
         end
      end
   end

   // A flush suppresses the pulse in the very cycle it arrives.
   assign div_bus.div_ready  = ready_q & ~div_bus.div_cancel;
   assign div_bus.div_result = result_q;

   assign div_bus.stallreq_exe = (cpu_rst_n != RST_ENABLE) && div_bus.div_start &&
                                 !div_bus.div_ready && !div_bus.div_cancel ? STOP : NOSTOP;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus cancel, reset and back-to-back sequences.
module tb_div_unit;

   logic cpu_clk_50M;
   logic cpu_rst_n;
   int   tests;
   int   fails;

   div_unit_if bus();

   div_unit dut (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst_n   (cpu_rst_n),
      .div_bus     (bus)
   );

   initial cpu_clk_50M = 1'b0;
   always #5 cpu_clk_50M = ~cpu_clk_50M;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_rem;
      logic [31:0] exp_quo;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic step();
      @(posedge cpu_clk_50M);
      #1;
   endtask

   // Wait up to max_cyc cycles for div_ready, counting from cycle t_in; returns the cycle seen or -1.
   task automatic wait_ready(input string name, input int t_in, input int max_cyc, output int t_out);
      bit stall_ok;
      int t;
      t = t_in;
      stall_ok = 1'b1;
      t_out = -1;
      while (t <= t_in + max_cyc) begin
         @(negedge cpu_clk_50M);
         if (bus.div_ready === 1'b1) begin
            t_out = t;
            break;
         end
         if (bus.stallreq_exe !== 1'b1) stall_ok = 1'b0;
         t++;
         step();
      end
      chk($sformatf("%s stall_while_pending", name), 64'(stall_ok), 64'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int t_rdy;
      div_unit_pkg::div_result_t res;
      string nm;
      nm = $sformatf("vec%0d", idx);
      bus.div_signed  = v.sgn;
      bus.div_opdata1 = v.a;
      bus.div_opdata2 = v.b;
      bus.div_start   = 1'b1;
      wait_ready(nm, 0, 40, t_rdy);
      chk($sformatf("%s latency", nm), 64'(t_rdy), 64'(v.lat));
      res = bus.div_result;
      chk($sformatf("%s result", nm), {res.rem, res.quo}, {v.exp_rem, v.exp_quo});
      chk($sformatf("%s stall_at_ready", nm), 64'(bus.stallreq_exe), 64'd0);
      step();
      bus.div_start = 1'b0;
      @(negedge cpu_clk_50M);
      res = bus.div_result;
      chk($sformatf("%s pulse_one_cycle", nm), 64'(bus.div_ready), 64'd0);
      chk($sformatf("%s result_hold", nm), {res.rem, res.quo}, {v.exp_rem, v.exp_quo});
      step();
   endtask

   initial begin
      int t_rdy;
      bit pulse_seen;
      div_unit_pkg::div_result_t res;
      logic [63:0] prev;

      tests = 0;
      fails = 0;
      //          sgn   a              b              rem            quo            lat
      vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'h00000002,  32'h0000000E,  33};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  33};
      vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'h00000001,  32'hFFFFFFFD,  33};
      vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  32'h80000000,  33};
      vecs[4]  = '{1'b0, 32'd5,         32'd0,         32'h00000005,  32'hFFFFFFFF,  1};
      vecs[5]  = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  32'hFFFFFFFF,  1};
      vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'h00000000,  32'hFFFFFFFF,  33};
      vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  32'h00000001,  33};
      vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'hFFFFFFFE,  32'h0000000E,  33};
      vecs[9]  = '{1'b0, 32'd3,         32'd7,         32'h00000003,  32'h00000000,  33};
      vecs[10] = '{1'b1, 32'h80000000,  32'd2,         32'h00000000,  32'hC0000000,  33};

      // Reset state, with start already asserted: no stall while in reset.
      cpu_rst_n       = 1'b0;
      bus.div_start   = 1'b1;
      bus.div_signed  = 1'b0;
      bus.div_opdata1 = 32'd100;
      bus.div_opdata2 = 32'd7;
      bus.div_cancel  = 1'b0;
      repeat (3) @(posedge cpu_clk_50M);
      @(negedge cpu_clk_50M);
      res = bus.div_result;
      chk("reset ready", 64'(bus.div_ready), 64'd0);
      chk("reset result", {res.rem, res.quo}, 64'd0);
      chk("reset stall", 64'(bus.stallreq_exe), 64'd0);
      bus.div_start = 1'b0;
      step();
      cpu_rst_n = 1'b1;
      step();

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Cancel at T10: stall drops in that cycle, no pulse, result untouched.
      prev = {vecs[10].exp_rem, vecs[10].exp_quo};
      bus.div_signed  = 1'b0;
      bus.div_opdata1 = 32'd100;
      bus.div_opdata2 = 32'd7;
      bus.div_start   = 1'b1;
      repeat (10) step();
      bus.div_cancel = 1'b1;
      @(negedge cpu_clk_50M);
      chk("cancel stall_T10", 64'(bus.stallreq_exe), 64'd0);
      chk("cancel ready_T10", 64'(bus.div_ready), 64'd0);
      step();
      bus.div_cancel = 1'b0;
      bus.div_start  = 1'b0;
      pulse_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge cpu_clk_50M);
         if (bus.div_ready === 1'b1) pulse_seen = 1'b1;
         step();
      end
      res = bus.div_result;
      chk("cancel no_pulse", 64'(pulse_seen), 64'd0);
      chk("cancel result_kept", {res.rem, res.quo}, prev);

      // Operands change mid-BUSY: the latched values must be used.
      bus.div_signed  = 1'b0;
      bus.div_opdata1 = 32'd1000;
      bus.div_opdata2 = 32'd9;
      bus.div_start   = 1'b1;
      repeat (5) step();
      bus.div_opdata1 = 32'd17;
      bus.div_opdata2 = 32'd0;
      bus.div_signed  = 1'b1;
      wait_ready("latch", 5, 40, t_rdy);
      res = bus.div_result;
      chk("latch latency", 64'(t_rdy), 64'd33);
      chk("latch result", {res.rem, res.quo}, {32'd1, 32'd111});
      step();
      bus.div_start = 1'b0;
      step();

      // Asynchronous reset at T15 clears everything at once; no result afterwards.
      bus.div_signed  = 1'b0;
      bus.div_opdata1 = 32'd100;
      bus.div_opdata2 = 32'd7;
      bus.div_start   = 1'b1;
      repeat (15) step();
      #1 cpu_rst_n = 1'b0;
      #1;
      res = bus.div_result;
      chk("async_rst ready", 64'(bus.div_ready), 64'd0);
      chk("async_rst result", {res.rem, res.quo}, 64'd0);
      chk("async_rst stall", 64'(bus.stallreq_exe), 64'd0);
      step();
      bus.div_start = 1'b0;
      step();
      cpu_rst_n = 1'b1;
      pulse_seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge cpu_clk_50M);
         if (bus.div_ready === 1'b1) pulse_seen = 1'b1;
         step();
      end
      chk("async_rst no_pulse", 64'(pulse_seen), 64'd0);

      // Back-to-back with start held: 9/3 ready at T33, 10/4 ready at T67.
      bus.div_signed  = 1'b0;
      bus.div_opdata1 = 32'd9;
      bus.div_opdata2 = 32'd3;
      bus.div_start   = 1'b1;
      wait_ready("b2b_first", 0, 40, t_rdy);
      res = bus.div_result;
      chk("b2b_first latency", 64'(t_rdy), 64'd33);
      chk("b2b_first result", {res.rem, res.quo}, {32'd0, 32'd3});
      step();
      bus.div_opdata1 = 32'd10;
      bus.div_opdata2 = 32'd4;
      wait_ready("b2b_second", 34, 40, t_rdy);
      res = bus.div_result;
      chk("b2b_second latency", 64'(t_rdy), 64'd67);
      chk("b2b_second result", {res.rem, res.quo}, {32'd2, 32'd2});
      step();
      bus.div_start = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
